// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with terminal-count pulse and optional auto-reload.
module countdown_timer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE   = 100000000,
  parameter int unsigned PRESCALE_W = 27
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(PRESCALE - 1);

  state_t                state;
  logic [WIDTH-1:0]      reload_reg;
  logic [PRESCALE_W-1:0] prescaler;
  logic                  tick;

  // One count step per PRESCALE cycles spent in RUN
  assign tick = (state == S_RUN) && (prescaler == PS_LAST);

  // Status flags are a direct decode of the state register
  assign busy = (state == S_RUN) || (state == S_PAUSED);
  assign done = (state == S_DONE);

  // Timer FSM, count, reload register, prescaler and tc pulse
  always_ff @(posedge clk_100M) begin
    tc <= 1'b0;
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      reload_reg <= '0;
      prescaler  <= '0;
    end else if (load) begin
      count      <= load_val;
      reload_reg <= load_val;
      prescaler  <= '0;
      state      <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              prescaler <= '0;
              state     <= S_RUN;
            end else begin
              tc    <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (pause) begin
            // a coincident tick is dropped; prescaler and count hold
            state <= S_PAUSED;
          end else if (tick) begin
            prescaler <= '0;
            if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else if (count == WIDTH'(1)) begin
              count <= '0;
              tc    <= 1'b1;
              if (!auto_reload) state <= S_DONE;
            end else begin
              // zero held for one full tick period before reloading
              count <= reload_reg;
              if (reload_reg == '0) tc <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + PRESCALE_W'(1);
          end
        end
        S_PAUSED: begin
          if (start) state <= S_RUN;
        end
        S_DONE: begin
          if (start) begin
            if (reload_reg != '0) begin
              count     <= reload_reg;
              prescaler <= '0;
              state     <= S_RUN;
            end else begin
              tc <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random traffic vs a behavioural model.
module tb_countdown_timer;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned PRESCALE   = 4;
  localparam int unsigned PRESCALE_W = 27;

  logic             clk_100M = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: activity flags, value, reload and time within the current tick period
  bit running, frozen, finished;
  int m_cnt, m_rel, m_elapsed;
  bit m_tc;

  int cyc_n = 0;
  int tc_cyc = -1;
  int tc_n = 0;

  countdown_timer #(
    .WIDTH(WIDTH), .PRESCALE(PRESCALE), .PRESCALE_W(PRESCALE_W)
  ) dut (
    .clk_100M(clk_100M), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .auto_reload(auto_reload),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the spec rules for one rising edge to the model
  task automatic model_edge();
    bit period_end;
    m_tc = 1'b0;
    if (rst) begin
      running = 0; frozen = 0; finished = 0;
      m_cnt = 0; m_rel = 0; m_elapsed = 0;
    end else if (load) begin
      running = 0; frozen = 0; finished = 0;
      m_cnt = int'(load_val); m_rel = int'(load_val); m_elapsed = 0;
    end else if (running) begin
      if (pause) begin
        running = 0; frozen = 1;
      end else begin
        m_elapsed = m_elapsed + 1;
        period_end = (m_elapsed == PRESCALE);
        if (period_end) begin
          m_elapsed = 0;
          if (m_cnt == 0) begin
            m_cnt = m_rel;
            m_tc  = (m_rel == 0);
          end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
              m_tc = 1'b1;
              if (!auto_reload) begin running = 0; finished = 1; end
            end
          end
        end
      end
    end else if (frozen) begin
      if (start) begin frozen = 0; running = 1; end
    end else if (finished) begin
      if (start) begin
        if (m_rel != 0) begin
          m_cnt = m_rel; m_elapsed = 0; finished = 0; running = 1;
        end else begin
          m_tc = 1'b1;
        end
      end
    end else begin
      if (start) begin
        if (m_cnt != 0) begin running = 1; m_elapsed = 0; end
        else begin finished = 1; m_tc = 1'b1; end
      end
    end
  endtask

  // One clock: update the model at the edge, compare all outputs just after it
  task automatic step();
    @(posedge clk_100M);
    model_edge();
    #1;
    cyc_n++;
    if (tc === 1'b1) begin tc_cyc = cyc_n; tc_n++; end
    check("count", 32'(count), 32'(m_cnt));
    check("tc",    32'(tc),    32'(m_tc));
    check("busy",  32'(busy),  32'(running | frozen));
    check("done",  32'(done),  32'(finished));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input bit l, input int lv, input bit s, input bit p);
    load = l; load_val = WIDTH'(lv); start = s; pause = p;
  endtask

  int e0;
  int t_first;
  logic [WIDTH-1:0] held;

  initial begin
    // 1. reset, mid-activity reset, start from zero
    rst = 1'b1; steps(2);
    rst = 1'b0; drive(1, 5, 0, 0); step(); drive(0, 0, 1, 0); step();
    drive(0, 0, 0, 0); steps(6);
    rst = 1'b1; steps(3); rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tc", 32'(tc), 0);
    drive(0, 0, 1, 0); step(); drive(0, 0, 0, 0);
    check("zero_start_tc", 32'(tc), 1);
    check("zero_start_done", 32'(done), 1);
    step();
    check("zero_start_tc_once", 32'(tc), 0);

    // 2. single run of 3
    drive(1, 3, 0, 0); step();
    drive(0, 0, 1, 0); step(); e0 = cyc_n; drive(0, 0, 0, 0);
    steps(4);  check("run_e4", 32'(count), 2);
    steps(4);  check("run_e8", 32'(count), 1);
    steps(4);  check("run_e12", 32'(count), 0);
    check("run_tc_time", 32'(tc_cyc - e0), 12);
    steps(50); check("run_hold_zero", 32'(count), 0);
    check("run_done", 32'(done), 1);

    // 3. auto-reload, then drop auto_reload
    auto_reload = 1'b1;
    drive(1, 2, 0, 0); step();
    drive(0, 0, 1, 0); step(); e0 = cyc_n; drive(0, 0, 0, 0);
    tc_n = 0; steps(40);
    check("ar_tc_pulses", 32'(tc_n), 3);
    check("ar_busy", 32'(busy), 1);
    auto_reload = 1'b0; steps(20);
    check("ar_off_done", 32'(done), 1);

    // 4. pause for 10 frozen edges, resume delays tc by exactly 10
    drive(1, 5, 0, 0); step();
    drive(0, 0, 1, 0); step(); e0 = cyc_n; drive(0, 0, 0, 0);
    steps(6);
    drive(0, 0, 0, 1); steps(9);
    drive(0, 0, 1, 1); step();
    drive(0, 0, 0, 0); tc_cyc = -1; steps(30);
    check("pause_delay", 32'(tc_cyc - e0), 30);
    drive(1, 5, 0, 0); step();
    drive(0, 0, 1, 0); step(); drive(0, 0, 0, 0); steps(2);
    drive(0, 0, 1, 1); step(); held = count;
    drive(0, 0, 0, 1); steps(8);
    check("start_pause_frozen", 32'(count), 32'(held));
    check("start_pause_busy", 32'(busy), 1);

    // 5. load override mid-run, then full-width run
    drive(0, 0, 1, 0); steps(3);
    drive(1, 9, 1, 1); step();
    check("ovr_count", 32'(count), 9);
    check("ovr_busy", 32'(busy), 0);
    check("ovr_tc", 32'(tc), 0);
    drive(1, 15, 0, 0); step();
    drive(0, 0, 1, 0); step(); e0 = cyc_n; drive(0, 0, 0, 0);
    tc_n = 0; steps(70);
    check("max_tc_time", 32'(tc_cyc - e0), 60);
    check("max_tc_once", 32'(tc_n), 1);
    check("max_no_wrap", 32'(count), 0);

    // 6. restart from DONE, then zero reload in DONE
    drive(1, 3, 0, 0); step(); drive(0, 0, 1, 0); step(); drive(0, 0, 0, 0); steps(15);
    drive(0, 0, 1, 0); step(); e0 = cyc_n; drive(0, 0, 0, 0);
    check("restart_count", 32'(count), 3);
    check("restart_busy", 32'(busy), 1);
    tc_n = 0; steps(16);
    t_first = tc_cyc - e0;
    check("restart_tc_time", 32'(t_first), 12);
    check("restart_tc_once", 32'(tc_n), 1);
    drive(1, 0, 0, 0); step(); drive(0, 0, 1, 0); step(); drive(0, 0, 0, 0); step();
    drive(0, 0, 1, 0); step(); drive(0, 0, 0, 0);
    check("zero_done_tc", 32'(tc), 1);
    check("zero_done_stays", 32'(done), 1);
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      load        = ($urandom_range(0, 19) == 0);
      load_val    = WIDTH'($urandom_range(0, 15));
      start       = ($urandom_range(0, 3) == 0);
      pause       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) auto_reload = ~auto_reload;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
